// File: rtl/meas_scan_ctrl.sv
// meas_scan_ctrl: steps a channel mux through C_INUM inputs, settles, captures and hands off each sample.
// Define MEAS_SCAN_PARITY_EN to add O_parity, the even parity of the captured sample.
module meas_scan_ctrl #(
  parameter int C_INUM    = 48,
  parameter int C_IDWIDTH = 24,
  parameter int C_ISWIDTH = 6,
  parameter int C_SETTLE  = 2
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_start,
  input  logic                 I_abort,
  output logic [C_ISWIDTH-1:0] O_sel,
  input  logic [C_IDWIDTH-1:0] I_mdata,
  output logic [C_IDWIDTH-1:0] O_data,
  output logic [C_ISWIDTH-1:0] O_idx,
  output logic                 O_valid,
  input  logic                 I_ready,
  output logic                 O_busy,
  output logic                 O_done
`ifdef MEAS_SCAN_PARITY_EN
  ,
  output logic                 O_parity
`endif
);

  // state    | meaning
  // S_IDLE   | waiting for I_start, outputs quiet
  // S_SETTLE | select stable, counting C_SETTLE cycles
  // S_CAPTURE| latch mux data and channel index
  // S_OUTPUT | O_valid high until I_ready handshake
  // S_DONE   | one-cycle O_done pulse, then idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_OUTPUT,
    S_DONE
  } state_t;

  localparam int                 CW          = 4;
  localparam logic [CW-1:0]        SETTLE_LAST = CW'(C_SETTLE - 1);
  localparam logic [C_ISWIDTH-1:0] SEL_LAST    = C_ISWIDTH'(C_INUM - 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [C_ISWIDTH-1:0]   sel_q, sel_d;
  logic [C_ISWIDTH-1:0]   idx_q, idx_d;
  logic [C_IDWIDTH-1:0]   data_q, data_d;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (I_start && !I_abort) begin
          state_d = S_SETTLE;
          sel_d   = '0;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      S_CAPTURE: begin
        data_d  = I_mdata;
        idx_d   = sel_q;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (I_ready) begin
          if (sel_q == SEL_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETTLE;
            sel_d   = sel_q + 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort beats any handshake or counter progress in the same cycle
    if (I_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sel_d   = '0;
      cnt_d   = '0;
    end
  end

  assign O_sel   = sel_q;
  assign O_data  = data_q;
  assign O_idx   = idx_q;
  assign O_valid = (state_q == S_OUTPUT);
  assign O_busy  = (state_q != S_IDLE);
  assign O_done  = (state_q == S_DONE);

`ifdef MEAS_SCAN_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (state_q == S_CAPTURE) parity_d = ^I_mdata;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign O_parity = parity_q;
`endif

endmodule
